onehot_decoder_scan: RTL

Parametrised, registered binary-to-one-hot decoder with a built-in scan sequencer. It generalises the 3-to-8 decoder to SEL_W select bits, a configurable output count, and selectable output polarity. A second mode steps the active output round-robin at a programmable rate, for multiplexed 7-segment digit select or LED scanning. It sits between control logic and the board-level select and enable lines.

---
 rtl/onehot_decoder_scan_pkg.sv | 25 ++
 rtl/onehot_decoder_scan_if.sv | 25 ++
 rtl/onehot_decoder_scan_dec.sv | 24 ++
 rtl/onehot_decoder_scan.sv | 109 ++++++++++
 4 files changed

// File: rtl/onehot_decoder_scan_pkg.sv
// Shared state encoding, mode constants and next-state helper for the
// one-hot decoder / scan sequencer.
package onehot_decoder_scan_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIRECT = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // The state is re-derived from en/mode every cycle, so the FSM has no memory of its own.
    function automatic logic [1:0] next_state(input logic en, input logic mode);
        logic [1:0] st;
        if (!en) begin
            st = IDLE;
        end else if (mode == MODE_SCAN) begin
            st = SCAN;
        end else begin
            st = DIRECT;
        end
        return st;
    endfunction

endpackage

// File: rtl/onehot_decoder_scan_if.sv
// Control/select bundle between the controlling logic (master) and the
// decoder (slave).
interface onehot_decoder_scan_if #(
    parameter int SEL_W = 3,
    parameter int OUT_N = 8,
    parameter int DIV_W = 16
);
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [DIV_W-1:0] div;
    logic [OUT_N-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             step;

    modport master (
        output en, mode, sel, div,
        input  out, idx, step
    );

    modport slave (
        input  en, mode, sel, div,
        output out, idx, step
    );
endinterface

// File: rtl/onehot_decoder_scan_dec.sv
// Combinational binary-to-one-hot map; values at or above OUT_N give all zeros.
module onehot_dec
    import onehot_decoder_scan_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int OUT_N = 8
) (
    input  logic [SEL_W-1:0] bin,
    output logic [OUT_N-1:0] onehot
);

    // One comparator per output; out-of-range values simply match nothing.
    always_comb begin
        onehot = {OUT_N{1'b0}};
        for (int i = 0; i < OUT_N; i++) begin
            if (bin == SEL_W'(i)) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/onehot_decoder_scan.sv
// Registered one-hot decoder with round-robin scan mode; holds the FSM,
// the dwell prescaler and the index register.
module onehot_decoder_scan
    import onehot_decoder_scan_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int OUT_N      = 8,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_decoder_scan_if.slave   bus
);

    localparam logic [OUT_N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_N{1'b1}} : {OUT_N{1'b0}};
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_N - 1);

    logic             armed_r;
    logic [1:0]       state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [SEL_W-1:0] idx_r;
    logic [OUT_N-1:0] out_r;
    logic             step_r;

    logic [1:0]       state_nxt_s;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic [SEL_W-1:0] idx_nxt_s;
    logic             step_nxt_s;
    logic [OUT_N-1:0] dec_s;
    logic [OUT_N-1:0] out_nxt_s;

    // Decoding the next index keeps out and idx aligned on the same edge.
    onehot_dec #(
        .SEL_W (SEL_W),
        .OUT_N (OUT_N)
    ) u_dec (
        .bin    (idx_nxt_s),
        .onehot (dec_s)
    );

    // Next-state, prescaler and index computation.
    always_comb begin
        state_nxt_s = next_state(bus.en, bus.mode);
        cnt_nxt_s   = {DIV_W{1'b0}};
        idx_nxt_s   = {SEL_W{1'b0}};
        step_nxt_s  = 1'b0;
        case (state_nxt_s)
            DIRECT: begin
                idx_nxt_s = bus.sel;
            end
            SCAN: begin
                if (state_r != SCAN) begin
                    cnt_nxt_s  = {DIV_W{1'b0}};
                    idx_nxt_s  = {SEL_W{1'b0}};
                    step_nxt_s = 1'b0;
                end else if (cnt_r >= bus.div) begin
                    // >= rather than == so a lowered div never strands the counter.
                    cnt_nxt_s  = {DIV_W{1'b0}};
                    idx_nxt_s  = (idx_r == IDX_LAST) ? {SEL_W{1'b0}} : idx_r + SEL_W'(1);
                    step_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s  = cnt_r + DIV_W'(1);
                    idx_nxt_s  = idx_r;
                    step_nxt_s = 1'b0;
                end
            end
            default: begin
                cnt_nxt_s  = {DIV_W{1'b0}};
                idx_nxt_s  = {SEL_W{1'b0}};
                step_nxt_s = 1'b0;
            end
        endcase
    end

    // Polarity is applied once, right before the output register.
    always_comb begin
        if (state_nxt_s == IDLE) begin
            out_nxt_s = INACTIVE;
        end else begin
            out_nxt_s = dec_s ^ INACTIVE;
        end
    end

    // State registers; the first edge after reset release only arms the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b0;
            state_r <= IDLE;
            cnt_r   <= {DIV_W{1'b0}};
            idx_r   <= {SEL_W{1'b0}};
            out_r   <= INACTIVE;
            step_r  <= 1'b0;
        end else if (!armed_r) begin
            armed_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            out_r   <= out_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

    assign bus.out  = out_r;
    assign bus.idx  = idx_r;
    assign bus.step = step_r;

endmodule
